// File: rtl/sdram_p0_frontend.sv
// Client front end for SDRAM controller port 0: in-order request FIFO, one-at-a-time
// p0 issue FSM, and a one-line read buffer that serves repeat reads of a burst line.
module sdram_p0_frontend #(
   parameter int ADDR_WIDTH   = 25,
   parameter int DATA_WIDTH   = 16,
   parameter int BURST_LENGTH = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int LINE_BUF_EN  = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               init_complete,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic                               req_we,
   input  logic [ADDR_WIDTH-1:0]              req_addr,
   input  logic [DATA_WIDTH-1:0]              req_wdata,
   input  logic [1:0]                         req_be,
   output logic                               rsp_valid,
   output logic [DATA_WIDTH-1:0]              rsp_data,
   output logic [ADDR_WIDTH-1:0]              p0_addr,
   output logic [DATA_WIDTH-1:0]              p0_data,
   output logic [1:0]                         p0_byte_en,
   output logic                               p0_wr_req,
   output logic                               p0_rd_req,
   input  logic [DATA_WIDTH*BURST_LENGTH-1:0] p0_q,
   input  logic                               p0_ready,
   input  logic                               p0_available
);
   localparam int WIDX = $clog2(BURST_LENGTH);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int TW   = ADDR_WIDTH - WIDX;
   localparam int LW   = DATA_WIDTH * BURST_LENGTH;

   localparam logic [PW:0]           CNT_ZERO  = (PW+1)'(0);
   localparam logic [PW:0]           CNT_ONE   = (PW+1)'(1);
   localparam logic [PW:0]           CNT_FULL  = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW-1:0]         PTR_ZERO  = PW'(0);
   localparam logic [PW-1:0]         PTR_ONE   = PW'(1);
   localparam logic [WIDX-1:0]       WORD_ZERO = WIDX'(0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
   localparam logic [TW-1:0]         TAG_ZERO  = {TW{1'b0}};

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]           count_q, count_d;
   logic                  req_ready_q, req_ready_d;
   logic                  fifo_we_q    [FIFO_DEPTH];
   logic                  fifo_we_d    [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_addr_d  [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_wdata_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_wdata_d [FIFO_DEPTH];
   logic [1:0]            fifo_be_q    [FIFO_DEPTH];
   logic [1:0]            fifo_be_d    [FIFO_DEPTH];
   logic [LW-1:0]         buf_line_q, buf_line_d;
   logic [TW-1:0]         buf_tag_q, buf_tag_d;
   logic                  buf_valid_q, buf_valid_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic [ADDR_WIDTH-1:0] p0_addr_q, p0_addr_d;
   logic [DATA_WIDTH-1:0] p0_data_q, p0_data_d;
   logic [1:0]            p0_be_q, p0_be_d;
   logic                  p0_wr_req_q, p0_wr_req_d;
   logic                  p0_rd_req_q, p0_rd_req_d;

   logic                  push_s, pop_s, empty_s, hit_s, finish_s;
   logic                  head_we_s;
   logic [ADDR_WIDTH-1:0] head_addr_s;
   logic [DATA_WIDTH-1:0] head_wdata_s;
   logic [1:0]            head_be_s;
   logic [TW-1:0]         head_tag_s;
   logic [WIDX-1:0]       head_word_s;

   function automatic logic [DATA_WIDTH-1:0] word_sel(input logic [LW-1:0] line,
                                                      input logic [WIDX-1:0] idx);
      word_sel = line[DATA_WIDTH*int'(idx) +: DATA_WIDTH];
   endfunction

   assign push_s       = req_valid & req_ready_q;
   assign empty_s      = (count_q == CNT_ZERO);
   assign head_we_s    = fifo_we_q[rd_ptr_q];
   assign head_addr_s  = fifo_addr_q[rd_ptr_q];
   assign head_wdata_s = fifo_wdata_q[rd_ptr_q];
   assign head_be_s    = fifo_be_q[rd_ptr_q];
   assign head_tag_s   = head_addr_s[ADDR_WIDTH-1:WIDX];
   assign head_word_s  = head_addr_s[WIDX-1:0];
   assign hit_s        = (LINE_BUF_EN != 0) && !head_we_s && buf_valid_q && (buf_tag_q == head_tag_s);

   // Queue bookkeeping; ready is registered from the next-cycle occupancy so it never sees the pop.
   always_comb begin
      fifo_we_d    = fifo_we_q;
      fifo_addr_d  = fifo_addr_q;
      fifo_wdata_d = fifo_wdata_q;
      fifo_be_d    = fifo_be_q;
      rd_ptr_d     = rd_ptr_q;
      if (push_s) begin
         fifo_we_d[wr_ptr_q]    = req_we;
         fifo_addr_d[wr_ptr_q]  = req_addr;
         fifo_wdata_d[wr_ptr_q] = req_wdata;
         fifo_be_d[wr_ptr_q]    = req_be;
         wr_ptr_d               = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      req_ready_d = (count_d != CNT_FULL);
   end

   // Issue FSM, line buffer and response generation.
   always_comb begin
      state_d     = state_q;
      pop_s       = 1'b0;
      finish_s    = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      p0_addr_d   = p0_addr_q;
      p0_data_d   = p0_data_q;
      p0_be_d     = p0_be_q;
      p0_wr_req_d = 1'b0;
      p0_rd_req_d = 1'b0;
      buf_line_d  = buf_line_q;
      buf_tag_d   = buf_tag_q;
      buf_valid_d = buf_valid_q;
      case (state_q)
         S_IDLE: begin
            if (!empty_s && init_complete) begin
               if (hit_s) begin
                  pop_s       = 1'b1;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = word_sel(buf_line_q, head_word_s);
               end else if (p0_ready) begin
                  state_d = S_ISSUE;
                  if (head_we_s) begin
                     p0_addr_d   = head_addr_s;
                     p0_data_d   = head_wdata_s;
                     p0_be_d     = head_be_s;
                     p0_wr_req_d = 1'b1;
                     // A write into the buffered line makes the copy stale.
                     if (buf_tag_q == head_tag_s) begin
                        buf_valid_d = 1'b0;
                     end else begin
                        buf_valid_d = buf_valid_q;
                     end
                  end else begin
                     p0_addr_d   = {head_tag_s, WORD_ZERO};
                     p0_rd_req_d = 1'b1;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (p0_available) begin
               finish_s = 1'b1;
            end else if (!p0_ready) begin
               state_d = S_WAIT_DONE;
            end else begin
               state_d = S_WAIT_BUSY;
            end
         end
         S_WAIT_DONE: begin
            if (head_we_s ? p0_ready : p0_available) begin
               finish_s = 1'b1;
            end else begin
               state_d = S_WAIT_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (finish_s) begin
         pop_s   = 1'b1;
         state_d = S_IDLE;
         if (!head_we_s) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = word_sel(p0_q, head_word_s);
            if (LINE_BUF_EN != 0) begin
               buf_line_d  = p0_q;
               buf_tag_d   = head_tag_s;
               buf_valid_d = 1'b1;
            end else begin
               buf_valid_d = 1'b0;
            end
         end else begin
            rsp_valid_d = 1'b0;
         end
      end else begin
         pop_s = pop_s;
      end
   end

   // Control and output registers; reset abandons any in-flight operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= PTR_ZERO;
         rd_ptr_q    <= PTR_ZERO;
         count_q     <= CNT_ZERO;
         req_ready_q <= 1'b0;
         buf_tag_q   <= TAG_ZERO;
         buf_valid_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= DATA_ZERO;
         p0_addr_q   <= ADDR_ZERO;
         p0_data_q   <= DATA_ZERO;
         p0_be_q     <= 2'b00;
         p0_wr_req_q <= 1'b0;
         p0_rd_req_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         req_ready_q <= req_ready_d;
         buf_tag_q   <= buf_tag_d;
         buf_valid_q <= buf_valid_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         p0_addr_q   <= p0_addr_d;
         p0_data_q   <= p0_data_d;
         p0_be_q     <= p0_be_d;
         p0_wr_req_q <= p0_wr_req_d;
         p0_rd_req_q <= p0_rd_req_d;
      end
   end

   // Payload storage needs no reset: occupancy and buffer valid qualify it.
   always_ff @(posedge clk) begin
      fifo_we_q    <= fifo_we_d;
      fifo_addr_q  <= fifo_addr_d;
      fifo_wdata_q <= fifo_wdata_d;
      fifo_be_q    <= fifo_be_d;
      buf_line_q   <= buf_line_d;
   end

   assign req_ready  = req_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign p0_addr    = p0_addr_q;
   assign p0_data    = p0_data_q;
   assign p0_byte_en = p0_be_q;
   assign p0_wr_req  = p0_wr_req_q;
   assign p0_rd_req  = p0_rd_req_q;
endmodule

// File: tb/tb_sdram_p0_frontend.sv
// Directed bench for sdram_p0_frontend with a simple behavioural port-0 controller model.
module tb_sdram_p0_frontend;
   localparam int AW = 25;
   localparam int DW = 16;
   localparam int BL = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset, init_complete, req_valid, req_ready, req_we;
   logic [AW-1:0]  req_addr;
   logic [DW-1:0]  req_wdata;
   logic [1:0]     req_be;
   logic           rsp_valid;
   logic [DW-1:0]  rsp_data;
   logic [AW-1:0]  p0_addr;
   logic [DW-1:0]  p0_data;
   logic [1:0]     p0_byte_en;
   logic           p0_wr_req, p0_rd_req;
   logic [DW*BL-1:0] p0_q = '0;
   logic           p0_ready = 1'b1;
   logic           p0_available = 1'b0;

   sdram_p0_frontend dut (
      .clk(clk), .reset(reset), .init_complete(init_complete),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .p0_addr(p0_addr), .p0_data(p0_data), .p0_byte_en(p0_byte_en),
      .p0_wr_req(p0_wr_req), .p0_rd_req(p0_rd_req),
      .p0_q(p0_q), .p0_ready(p0_ready), .p0_available(p0_available)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Controller model: backing memory, strobe log, response log.
   logic [DW-1:0] mem [int];
   int            lat = 3;
   int            busy = 0;
   logic          pend_rd = 1'b0;
   int            pend_base = 0;
   int            strobe_cnt = 0;
   logic          st_we   [$];
   logic [AW-1:0] st_addr [$];
   logic [DW-1:0] st_data [$];
   logic [1:0]    st_be   [$];
   logic [DW-1:0] rsp_q   [$];
   int            rsp_cyc_q [$];
   int            last_avail = -100;
   int            cyc = 0;
   int            push_cyc = 0;

   function automatic logic [DW-1:0] rd_word(input int a);
      return mem.exists(a) ? mem[a] : 16'h0000;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [DW-1:0] w;
      p0_available = 1'b0;
      if (rsp_valid) begin
         rsp_q.push_back(rsp_data);
         rsp_cyc_q.push_back(cyc);
      end
      if (busy > 0) begin
         if (busy == lat) chk("strobe_one_cycle", {62'd0, p0_rd_req, p0_wr_req}, 64'd0);
         busy = busy - 1;
         if (busy == 0) begin
            if (pend_rd) begin
               for (int k = 0; k < BL; k++) p0_q[DW*k +: DW] = rd_word(pend_base + k);
               p0_available = 1'b1;
               last_avail = cyc;
            end
            p0_ready = 1'b1;
         end
      end else if (p0_rd_req || p0_wr_req) begin
         chk("strobe_exclusive", {63'd0, p0_rd_req & p0_wr_req}, 64'd0);
         strobe_cnt++;
         st_we.push_back(p0_wr_req);
         st_addr.push_back(p0_addr);
         st_data.push_back(p0_data);
         st_be.push_back(p0_byte_en);
         if (p0_wr_req) begin
            w = rd_word(int'(p0_addr));
            if (p0_byte_en[0]) w[7:0] = p0_data[7:0];
            if (p0_byte_en[1]) w[15:8] = p0_data[15:8];
            mem[int'(p0_addr)] = w;
            pend_rd = 1'b0;
         end else begin
            pend_rd = 1'b1;
            pend_base = int'(p0_addr);
         end
         p0_ready = 1'b0;
         busy = lat;
      end
   end

   task automatic wait_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
      int n;
      req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 100) begin
         wait_neg();
         n++;
      end
      if (!req_ready) chk("push_timeout", {63'd0, req_ready}, 64'd1);
      push_cyc = cyc;
      wait_neg();
      req_valid = 1'b0;
   endtask

   task automatic chk_outs_zero(input string name);
      chk(name, {rsp_valid, rsp_data, p0_addr, p0_data, p0_byte_en, p0_wr_req, p0_rd_req, req_ready}, 64'd0);
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [1:0]    be;
      logic          exp_strobe;
      logic [AW-1:0] exp_p0_addr;
      logic [DW-1:0] exp_rsp;
   } vec_t;

   task automatic run_vec(input vec_t v, input int idx);
      int s0, r0;
      s0 = strobe_cnt;
      r0 = rsp_q.size();
      drive(v.we, v.addr, v.wdata, v.be);
      repeat (12) wait_neg();
      chk($sformatf("v%0d_strobes", idx), strobe_cnt - s0, {63'd0, v.exp_strobe});
      if (v.exp_strobe && strobe_cnt > s0) begin
         chk($sformatf("v%0d_p0_addr", idx), st_addr[s0], v.exp_p0_addr);
         chk($sformatf("v%0d_p0_is_wr", idx), st_we[s0], v.we);
         if (v.we) begin
            chk($sformatf("v%0d_p0_data", idx), st_data[s0], v.wdata);
            chk($sformatf("v%0d_p0_be", idx), st_be[s0], v.be);
         end
      end
      chk($sformatf("v%0d_rsp_count", idx), rsp_q.size() - r0, v.we ? 64'd0 : 64'd1);
      if (!v.we && rsp_q.size() > r0) begin
         chk($sformatf("v%0d_rsp_data", idx), rsp_q[r0], v.exp_rsp);
         if (v.exp_strobe) chk($sformatf("v%0d_miss_latency", idx), rsp_cyc_q[r0], last_avail + 1);
         else              chk($sformatf("v%0d_hit_latency", idx), rsp_cyc_q[r0], push_cyc + 2);
      end
   endtask

   vec_t tv [16];

   initial begin
      int s0, r0, n, t_rel;
      reset = 1'b1; init_complete = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_addr = '0; req_wdata = '0; req_be = 2'b00;

      tv[0]  = '{1'b1, 25'h0322020, 16'h1234, 2'b11, 1'b1, 25'h0322020, 16'h0000};
      tv[1]  = '{1'b1, 25'h0322021, 16'h5678, 2'b11, 1'b1, 25'h0322021, 16'h0000};
      tv[2]  = '{1'b1, 25'h0322022, 16'h9ABC, 2'b11, 1'b1, 25'h0322022, 16'h0000};
      tv[3]  = '{1'b1, 25'h0322023, 16'hDEF0, 2'b11, 1'b1, 25'h0322023, 16'h0000};
      tv[4]  = '{1'b1, 25'h0322024, 16'hFEDC, 2'b11, 1'b1, 25'h0322024, 16'h0000};
      tv[5]  = '{1'b1, 25'h0322025, 16'hBA98, 2'b11, 1'b1, 25'h0322025, 16'h0000};
      tv[6]  = '{1'b1, 25'h0322026, 16'h7654, 2'b11, 1'b1, 25'h0322026, 16'h0000};
      tv[7]  = '{1'b1, 25'h0322027, 16'h3210, 2'b11, 1'b1, 25'h0322027, 16'h0000};
      tv[8]  = '{1'b0, 25'h0322023, 16'h0000, 2'b00, 1'b1, 25'h0322020, 16'hDEF0};
      tv[9]  = '{1'b0, 25'h0322025, 16'h0000, 2'b00, 1'b0, 25'h0000000, 16'hBA98};
      tv[10] = '{1'b1, 25'h0322021, 16'hAAAA, 2'b11, 1'b1, 25'h0322021, 16'h0000};
      tv[11] = '{1'b0, 25'h0322021, 16'h0000, 2'b00, 1'b1, 25'h0322020, 16'hAAAA};
      tv[12] = '{1'b0, 25'h0322027, 16'h0000, 2'b00, 1'b0, 25'h0000000, 16'h3210};
      tv[13] = '{1'b1, 25'h0322026, 16'h11FF, 2'b10, 1'b1, 25'h0322026, 16'h0000};
      tv[14] = '{1'b0, 25'h0322026, 16'h0000, 2'b00, 1'b1, 25'h0322020, 16'h1154};
      tv[15] = '{1'b0, 25'h0322020, 16'h0000, 2'b00, 1'b0, 25'h0000000, 16'h1234};

      repeat (3) @(negedge clk);
      #1;
      chk_outs_zero("reset_outputs");
      reset = 1'b0;
      init_complete = 1'b1;
      wait_neg();
      chk("ready_after_reset", {63'd0, req_ready}, 64'd1);

      for (int i = 0; i < 16; i++) run_vec(tv[i], i);

      // Full queue while the controller is not initialised; responses must stay in order.
      init_complete = 1'b0;
      s0 = strobe_cnt;
      r0 = rsp_q.size();
      drive(1'b1, 25'h0100008, 16'h1111, 2'b11);
      drive(1'b1, 25'h0100009, 16'h2222, 2'b11);
      drive(1'b0, 25'h0100009, 16'h0000, 2'b00);
      drive(1'b0, 25'h0100008, 16'h0000, 2'b00);
      chk("full_ready_low", {63'd0, req_ready}, 64'd0);
      req_we = 1'b1; req_addr = 25'h010000A; req_wdata = 16'h3333; req_be = 2'b11; req_valid = 1'b1;
      repeat (5) wait_neg();
      chk("full_ready_held", {63'd0, req_ready}, 64'd0);
      chk("no_strobe_before_init", strobe_cnt - s0, 64'd0);
      init_complete = 1'b1;
      drive(1'b1, 25'h010000A, 16'h3333, 2'b11);
      repeat (40) wait_neg();
      chk("init_strobe_count", strobe_cnt - s0, 64'd4);
      chk("init_rsp_count", rsp_q.size() - r0, 64'd2);
      if (rsp_q.size() >= r0 + 2) begin
         chk("init_rsp0", rsp_q[r0], 16'h2222);
         chk("init_rsp1", rsp_q[r0+1], 16'h1111);
      end
      if (strobe_cnt >= s0 + 4) begin
         chk("init_rd_addr", st_addr[s0+2], 25'h0100008);
         chk("init_last_wr_addr", st_addr[s0+3], 25'h010000A);
      end

      // Load the line buffer, then reset in the middle of a later read.
      run_vec('{1'b0, 25'h0322022, 16'h0000, 2'b00, 1'b1, 25'h0322020, 16'h9ABC}, 16);
      lat = 6;
      s0 = strobe_cnt;
      r0 = rsp_q.size();
      drive(1'b0, 25'h0400013, 16'h0000, 2'b00);
      n = 0;
      while (strobe_cnt == s0 && n < 20) begin
         wait_neg();
         n++;
      end
      chk("rst_op_strobe", strobe_cnt - s0, 64'd1);
      repeat (2) wait_neg();
      reset = 1'b1;
      wait_neg();
      chk_outs_zero("midop_reset_outputs");
      reset = 1'b0;
      t_rel = cyc;
      repeat (15) wait_neg();
      chk("midop_no_rsp", rsp_q.size() - r0, 64'd0);
      chk("midop_no_reissue", strobe_cnt - s0, 64'd1);
      chk("midop_avail_after_reset", {63'd0, last_avail > t_rel}, 64'd1);
      chk("midop_ready", {63'd0, req_ready}, 64'd1);
      lat = 3;
      run_vec('{1'b0, 25'h0322025, 16'h0000, 2'b00, 1'b1, 25'h0322020, 16'hBA98}, 17);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end
endmodule
